merge_radio: RTL and testbench

Differential-to-single-ended recovery block that terminates the split-radio link. It takes the complementary Plus/Minus pair driven by the split path, synchronises both legs into the local clock domain and checks that they stay complementary. It qualifies the link through a lock state machine and presents a single-ended `Receive` bit plus link-status flags to downstream logic.

---
 rtl/merge_radio_pkg.sv | 25 ++
 rtl/merge_radio_diff_sync.sv | 34 +++
 rtl/merge_radio.sv | 164 ++++++++++++++++
 tb/tb_merge_radio.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/merge_radio_pkg.sv
// -----------------------------------------------------------------------------
// merge_radio_pkg
// Shared definitions for the split-radio link terminator (merge_radio):
//   - state_e      : link qualification state encoding
//   - DEF_*        : default values for the merge_radio parameters
//   - sat_inc8     : saturating 8-bit increment used by the qualification counters
// -----------------------------------------------------------------------------
package merge_radio_pkg;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    LOCKED  = 2'd1,
    HOLD    = 2'd2,
    FAULT   = 2'd3
  } state_e;

  localparam int unsigned DEF_LOCK_COUNT  = 4;
  localparam int unsigned DEF_FAULT_LIMIT = 3;
  localparam int unsigned DEF_COUNT_W     = 16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/merge_radio_diff_sync.sv
// -----------------------------------------------------------------------------
// diff_sync
// Two-flop synchroniser for a 2-bit bus (both legs of a differential pair).
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, both stages clear to 0
//   d_i   - asynchronous input pair {plus, minus}
//   q_o   - synchronised pair (output of stage 2)
// -----------------------------------------------------------------------------
module diff_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);

  logic [1:0] s1_q;
  logic [1:0] s2_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes this a two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 2'b00;
      s2_q <= 2'b00;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/merge_radio.sv
// -----------------------------------------------------------------------------
// merge_radio
// Terminates the split-radio link: synchronises the complementary Plus/Minus
// legs, qualifies the link with a lock FSM (ACQUIRE/LOCKED/HOLD/FAULT) and
// presents a single-ended Receive bit plus status flags.
// Optional feature macro: MERGE_RADIO_EDGE_COUNT_EN adds the COUNT_W parameter
// and the Edge_Count output (Receive toggles counted while LOCKED).
// Ports:
//   Clock       - single clock, rising edge
//   Reset_Minus - asynchronous active-low reset
//   input_Plus  - positive leg (asynchronous)
//   input_Minus - negative leg (asynchronous)
//   Clear       - synchronous restart to ACQUIRE
//   Receive     - recovered data (registered)
//   Locked      - high in LOCKED and HOLD
//   Fault       - high in FAULT
//   Pair_Error  - one-cycle pulse per non-complementary sample
//   Edge_Count  - Receive toggle count (macro builds only)
// -----------------------------------------------------------------------------
module merge_radio
  import merge_radio_pkg::*;
#(
  parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int unsigned FAULT_LIMIT = DEF_FAULT_LIMIT
`ifdef MERGE_RADIO_EDGE_COUNT_EN
  , parameter int unsigned COUNT_W   = DEF_COUNT_W
`endif
) (
  input  logic               Clock,
  input  logic               Reset_Minus,
  input  logic               input_Plus,
  input  logic               input_Minus,
  input  logic               Clear,
  output logic               Receive,
  output logic               Locked,
  output logic               Fault,
  output logic               Pair_Error
`ifdef MERGE_RADIO_EDGE_COUNT_EN
  , output logic [COUNT_W-1:0] Edge_Count
`endif
);

  localparam logic [7:0] LOCK_CNT8  = LOCK_COUNT[7:0];
  localparam logic [7:0] FAULT_LIM8 = FAULT_LIMIT[7:0];

  logic [1:0] sample_w;
  logic       valid_w;
  logic       p_w;
  logic       fault_entry_w;

  state_e     state_q;
  logic [7:0] good_cnt_q;
  logic [7:0] bad_cnt_q;
  logic       receive_q;
  logic       locked_q;
  logic       fault_q;
  logic       pair_err_q;

  diff_sync u_sync (
    .clk   (Clock),
    .rst_n (Reset_Minus),
    .d_i   ({input_Plus, input_Minus}),
    .q_o   (sample_w)
  );

  assign valid_w = sample_w[1] ^ sample_w[0];
  assign p_w     = sample_w[1];

  // Invalid sample that exhausts the tolerance: straight from LOCKED when the
  // limit is 1, otherwise the FAULT_LIMIT-th consecutive miss seen in HOLD.
  assign fault_entry_w = !Clear && !valid_w &&
                         (((state_q == LOCKED) && (FAULT_LIMIT == 1)) ||
                          ((state_q == HOLD) && ((bad_cnt_q + 8'd1) >= FAULT_LIM8)));

  always_ff @(posedge Clock or negedge Reset_Minus) begin
    if (!Reset_Minus) begin
      state_q    <= ACQUIRE;
      good_cnt_q <= 8'd0;
      bad_cnt_q  <= 8'd0;
      receive_q  <= 1'b0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
      pair_err_q <= 1'b0;
    end else begin
      // Pair_Error reports every invalid sample regardless of state or Clear.
      pair_err_q <= !valid_w;
      if (Clear) begin
        state_q    <= ACQUIRE;
        good_cnt_q <= 8'd0;
        bad_cnt_q  <= 8'd0;
        receive_q  <= 1'b0;
        locked_q   <= 1'b0;
        fault_q    <= 1'b0;
      end else if (fault_entry_w) begin
        state_q    <= FAULT;
        bad_cnt_q  <= FAULT_LIM8;
        receive_q  <= 1'b0;
        locked_q   <= 1'b0;
        fault_q    <= 1'b1;
      end else begin
        unique case (state_q)
          ACQUIRE: begin
            if (valid_w) begin
              good_cnt_q <= sat_inc8(good_cnt_q);
              // This sample is the LOCK_COUNT-th consecutive valid one.
              if (good_cnt_q >= LOCK_CNT8 - 8'd1) begin
                state_q   <= LOCKED;
                receive_q <= p_w;
                locked_q  <= 1'b1;
              end
            end else begin
              good_cnt_q <= 8'd0;
            end
          end
          LOCKED: begin
            if (valid_w) begin
              receive_q <= p_w;
            end else begin
              state_q   <= HOLD;
              bad_cnt_q <= 8'd1;
            end
          end
          HOLD: begin
            if (valid_w) begin
              state_q   <= LOCKED;
              receive_q <= p_w;
              bad_cnt_q <= 8'd0;
            end else begin
              bad_cnt_q <= bad_cnt_q + 8'd1;
            end
          end
          FAULT: begin
            // Sticky until Clear or reset.
          end
          default: state_q <= ACQUIRE;
        endcase
      end
    end
  end

  assign Receive    = receive_q;
  assign Locked     = locked_q;
  assign Fault      = fault_q;
  assign Pair_Error = pair_err_q;

`ifdef MERGE_RADIO_EDGE_COUNT_EN
  logic [COUNT_W-1:0] edge_cnt_q;

  // Counts data toggles only while already LOCKED; the lock-entry load and the
  // HOLD->LOCKED reload do not count. Wraps naturally at all-ones.
  always_ff @(posedge Clock or negedge Reset_Minus) begin
    if (!Reset_Minus) begin
      edge_cnt_q <= '0;
    end else if (Clear || fault_entry_w) begin
      edge_cnt_q <= '0;
    end else if ((state_q == LOCKED) && valid_w && (p_w != receive_q)) begin
      edge_cnt_q <= edge_cnt_q + 1'b1;
    end
  end

  assign Edge_Count = edge_cnt_q;
`endif

endmodule

// File: tb/tb_merge_radio.sv
// -----------------------------------------------------------------------------
// tb_merge_radio
// Self-checking bench for merge_radio (LOCK_COUNT = 4, FAULT_LIMIT = 3).
// A behavioural model tracks the link as "seeking / linked / dead" using run
// lengths of valid and invalid samples; a compare process checks every output
// against it on each falling edge. Directed scenarios add literal expectations,
// followed by a randomised phase.
// -----------------------------------------------------------------------------
module tb_merge_radio;

  localparam int LC = 4;
  localparam int FL = 3;

  logic Clock       = 1'b0;
  logic Reset_Minus = 1'b0;
  logic input_Plus  = 1'b0;
  logic input_Minus = 1'b0;
  logic Clear       = 1'b0;
  logic Receive, Locked, Fault, Pair_Error;
`ifdef MERGE_RADIO_EDGE_COUNT_EN
  logic [15:0] Edge_Count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clock = ~Clock;

  merge_radio #(
    .LOCK_COUNT  (LC),
    .FAULT_LIMIT (FL)
  ) dut (
    .Clock       (Clock),
    .Reset_Minus (Reset_Minus),
    .input_Plus  (input_Plus),
    .input_Minus (input_Minus),
    .Clear       (Clear),
    .Receive     (Receive),
    .Locked      (Locked),
    .Fault       (Fault),
    .Pair_Error  (Pair_Error)
`ifdef MERGE_RADIO_EDGE_COUNT_EN
    , .Edge_Count (Edge_Count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_SEEK, M_LINK, M_DEAD} mmode_e;
  mmode_e     mode;
  logic [1:0] hist [2];   // hist[0] = newest captured pair, hist[1] = pair the logic sees
  logic [1:0] smp;
  int         run_good, run_bad;
  logic       exp_rx, exp_perr;
  logic [15:0] exp_edges;

  always @(posedge Clock or negedge Reset_Minus) begin
    if (!Reset_Minus) begin
      mode = M_SEEK; hist[0] = 2'b00; hist[1] = 2'b00;
      run_good = 0; run_bad = 0; exp_rx = 1'b0; exp_perr = 1'b0; exp_edges = '0;
    end else begin
      smp = hist[1];
      exp_perr = (smp[1] == smp[0]);
      if (Clear) begin
        mode = M_SEEK; run_good = 0; run_bad = 0; exp_rx = 1'b0; exp_edges = '0;
      end else begin
        case (mode)
          M_SEEK: begin
            run_good = exp_perr ? 0 : run_good + 1;
            if (run_good >= LC) begin
              mode = M_LINK; exp_rx = smp[1]; run_bad = 0;
            end
          end
          M_LINK: begin
            if (!exp_perr) begin
              if (run_bad == 0 && smp[1] != exp_rx) exp_edges = exp_edges + 16'd1;
              exp_rx = smp[1]; run_bad = 0;
            end else begin
              run_bad++;
              if (run_bad >= FL) begin
                mode = M_DEAD; exp_rx = 1'b0; exp_edges = '0;
              end
            end
          end
          default: ;
        endcase
      end
      hist[1] = hist[0];
      hist[0] = {input_Plus, input_Minus};
    end
  end

  always @(negedge Clock) begin
    check("rx_model",   Receive,    exp_rx);
    check("lock_model", Locked,     mode == M_LINK);
    check("flt_model",  Fault,      mode == M_DEAD);
    check("perr_model", Pair_Error, exp_perr);
`ifdef MERGE_RADIO_EDGE_COUNT_EN
    check("edge_model", Edge_Count, exp_edges);
`endif
  end

  task automatic drive(input logic p, input logic m);
    input_Plus  = p;
    input_Minus = m;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int cnt;
    int burst;
    logic vp;

    step(2);
    check("rst_rx",   Receive,    0);
    check("rst_lock", Locked,     0);
    check("rst_flt",  Fault,      0);
    check("rst_perr", Pair_Error, 0);

    // Lock acquisition: 3-edge pipeline plus 3 further counting edges.
    Reset_Minus = 1'b1;
    drive(1, 0);
    step(5);
    check("lock_edge5", Locked, 0);
    step(1);
    check("lock_edge6", Locked,     1);
    check("lock_rx",    Receive,    1);
    check("lock_perr",  Pair_Error, 0);

    // Data path: 3-edge latency.
    drive(0, 1);
    step(2);
    check("data_lat2", Receive, 1);
    step(1);
    check("data_lat3", Receive, 0);
    step(1);
    drive(1, 0);
    step(4);
    check("data_back", Receive, 1);
`ifdef MERGE_RADIO_EDGE_COUNT_EN
    check("data_edges", Edge_Count, 2);
`endif

    // Glitch tolerance: two invalid samples absorbed by HOLD.
    drive(1, 1);
    step(2);
    drive(0, 1);
    step(1);
    check("glitch_perr1", Pair_Error, 1);
    check("glitch_hold",  Receive,    1);
    check("glitch_lock",  Locked,     1);
    step(1);
    check("glitch_perr2", Pair_Error, 1);
    check("glitch_flt",   Fault,      0);
    step(1);
    check("glitch_rx",    Receive,    0);
    check("glitch_perr3", Pair_Error, 0);
    check("glitch_relk",  Locked,     1);

    // Fault entry: three invalid samples.
    drive(0, 0);
    step(3);
    drive(0, 1);
    step(1);
    check("fault_not_yet", Fault, 0);
    step(1);
    check("fault_set",  Fault,   1);
    check("fault_lock", Locked,  0);
    check("fault_rx",   Receive, 0);
    step(6);
    check("fault_sticky", Fault, 1);

    // Clear and reacquire with {0,1} already in the synchroniser.
    Clear = 1'b1;
    step(1);
    Clear = 1'b0;
    check("clr_flt",  Fault,   0);
    check("clr_lock", Locked,  0);
    step(3);
    check("clr_lock3", Locked, 0);
    step(1);
    check("clr_lock4", Locked,  1);
    check("clr_rx",    Receive, 0);

    // Reset mid-operation, between edges.
    drive(1, 0);
    step(4);
    @(posedge Clock);
    #2 Reset_Minus = 1'b0;
    #1;
    check("arst_rx",   Receive,    0);
    check("arst_lock", Locked,     0);
    check("arst_flt",  Fault,      0);
    check("arst_perr", Pair_Error, 0);
    step(1);
    Reset_Minus = 1'b1;
    drive(1, 0);
    cnt = 0;
    while (cnt < 20) begin
      @(negedge Clock);
      cnt++;
      if (Locked) break;
    end
    check("relock_edges", cnt, 6);

    // Randomised phase.
    vp = 1'b1;
    burst = 0;
    for (int i = 0; i < 2000; i++) begin
      if (burst > 0) begin
        burst--;
        drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end else begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 4) burst = $urandom_range(1, 4);
        else if (r < 20) vp = ~vp;
        drive(vp, ~vp);
      end
      Clear = ($urandom_range(0, 149) == 0);
      step(1);
    end
    Clear = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
